// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port between two producers.
// Define ARB_STATS_EN to add per-producer saturating write counters on WCNT0/WCNT1.
module fifo_wr_arbiter #(
  parameter int DW        = 10,
  parameter int MAX_BURST = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [DW-1:0] DIN0,
  input  logic          REQ1,
  input  logic [DW-1:0] DIN1,
  input  logic          FULL,
  output logic          GNT0,
  output logic          GNT1,
  output logic          WR_EN,
`ifdef ARB_STATS_EN
  output logic [15:0]   WCNT0,
  output logic [15:0]   WCNT1,
`endif
  output logic [DW-1:0] DOUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // A grant taken while the counter holds this value completes the burst.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] bcnt_q, bcnt_d;

  logic own_req;
  logic other_req;
  logic own_gnt;
  logic burst_done;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    GNT0 = 1'b0;
    GNT1 = 1'b0;
    DOUT = '0;
    // Outputs are also forced quiet while reset is asserted, so a burst cannot write during reset.
    if (RST) begin
      case (state_q)
        OWN0: begin
          GNT0 = REQ0 & ~FULL;
          DOUT = DIN0;
        end
        OWN1: begin
          GNT1 = REQ1 & ~FULL;
          DOUT = DIN1;
        end
        default: ;
      endcase
    end
    WR_EN = GNT0 | GNT1;
  end

  assign own_req    = (state_q == OWN0) ? REQ0 : REQ1;
  assign other_req  = (state_q == OWN0) ? REQ1 : REQ0;
  assign own_gnt    = GNT0 | GNT1;
  assign burst_done = own_gnt && (bcnt_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (REQ0 && REQ1) state_d = last_q ? OWN0 : OWN1;
        else if (REQ0)    state_d = OWN0;
        else if (REQ1)    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req || burst_done) begin
          last_d = (state_q == OWN1);
          bcnt_d = '0;
          // Hand straight to a waiting peer; a burst-limited owner with no rival keeps the port.
          if (other_req)     state_d = (state_q == OWN0) ? OWN1 : OWN0;
          else if (!own_req) state_d = IDLE;
        end else if (own_gnt) begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] wcnt0_q, wcnt0_d;
  logic [15:0] wcnt1_q, wcnt1_d;

  always_comb begin
    wcnt0_d = wcnt0_q;
    wcnt1_d = wcnt1_q;
    if (GNT0 && (wcnt0_q != 16'hFFFF)) wcnt0_d = wcnt0_q + 16'd1;
    if (GNT1 && (wcnt1_q != 16'hFFFF)) wcnt1_d = wcnt1_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wcnt0_q <= '0;
      wcnt1_q <= '0;
    end else begin
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
    end
  end

  assign WCNT0 = wcnt0_q;
  assign WCNT1 = wcnt1_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port (Din/WR_EN/Full, 10-bit) between two producers.
- Grants ownership in bursts of up to MAX_BURST words, stalls on Full, and drives the FIFO's WR_EN and Din directly.
- Sits between the two producer blocks and the FIFO write side; the read side is untouched.

Parameters:
- DW, 10, data width; matches FIFO Din/Dout.
- MAX_BURST, 4, maximum words per ownership period; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-low (0 = reset).
- REQ0  in  1  producer 0 has a word on DIN0.
- DIN0  in  DW  producer 0 data.
- REQ1  in  1  producer 1 has a word on DIN1.
- DIN1  in  DW  producer 1 data.
- FULL  in  1  FIFO Full flag.
- GNT0  out  1  producer 0 word accepted this cycle; producer advances to the next word on this edge.
- GNT1  out  1  producer 1 word accepted this cycle.
- WR_EN  out  1  to FIFO WR_EN.
- DOUT  out  DW  to FIFO Din.

Behaviour:
- State register: IDLE, OWN0, OWN1. Also holds a last-served pointer LAST (1 bit) and a burst counter BCNT (4 bits).
- Reset (RST=0 at an edge):
  - state=IDLE, LAST=1 (requester 0 wins the first tie), BCNT=0.
  - Because outputs are combinational from state, GNT0=GNT1=WR_EN=0 and DOUT=0 during and after reset.
  - Reset mid-burst aborts the burst; no partial write occurs after the reset edge.
- Outputs are combinational from state and inputs:
  - OWNx: GNTx = REQx & ~FULL; WR_EN = GNTx; DOUT = DINx.
  - IDLE: all grant/write outputs 0, DOUT = 0.
  - The non-owner's GNT is always 0.
- IDLE (arbitration cycle, no write):
  - Only REQ0 → OWN0. Only REQ1 → OWN1.
  - Both → OWN(~LAST). Neither → stay IDLE.
  - BCNT=0 on entry to any OWN state.
- OWNx:
  - BCNT increments on each GNTx. It holds while FULL=1 (stall) or while REQx=1 & FULL=1.
  - Release when REQx=0, or when a GNTx makes BCNT reach MAX_BURST.
  - On release: LAST=x and BCNT=0.
  - After release, if the other REQ=1 → go to OWN(other) directly, with no IDLE bubble.
  - Else if the release was burst-limited and REQx is still 1 → stay OWNx (new burst).
  - Else → IDLE.
- Latency:
  - First word from IDLE: REQ at edge t → grant in cycle t+1.
  - Handover between owners: zero bubble cycles.
- FULL: no write while FULL=1. Ownership is retained; no handover on FULL alone.
- Simultaneous REQ drop and FULL: treated as release (REQx=0 wins).
- FIFO one-write-per-cycle rule: at most one GNT per cycle; GNT0 & GNT1 is never 1.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output ports WCNT0[15:0] and WCNT1[15:0].
  - Each increments on its GNT, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST=0 for 2 cycles with REQ0=REQ1=1 → GNT0=GNT1=WR_EN=0, DOUT=0. Release reset → first grant goes to producer 0 (LAST=1).
- Single producer: REQ0=1 for 6 words (DIN0=32,29,53,7,8,9), FULL=0, MAX_BURST=4 → WR_EN high 6 cycles after the 1-cycle IDLE. State stays OWN0 across the burst boundary with no gap. DOUT sequence matches.
- Contention: REQ0=REQ1=1 continuously → grants alternate in bursts 0,0,0,0,1,1,1,1,0... with no idle cycle at handovers. GNT0 & GNT1 never both 1.
- Full stall: owner OWN1 with BCNT=2, then FULL=1 for 3 cycles → WR_EN=0 and GNT1=0. BCNT stays 2 and OWN1 is retained. After FULL=0, exactly 2 more words are written before handover.
- Early release: REQ0 drops after 1 word while REQ1=1 → next cycle is OWN1 with GNT1=1. LAST=0.
- ARB_STATS_EN: after the contention test runs 20 words → WCNT0+WCNT1=20. Force 65536 grants → WCNT0 saturates at 16'hFFFF.
